// File: rtl/baud_cfg_ctrl.sv
// Staged divisor configuration for baud_gen: commits {dlh,dll} atomically once the link is idle, on a br tick.
// Optional build macro DIV_READBACK_EN: addr0/addr1 reads return the active divisor instead of 8'h00.
module baud_cfg_ctrl #(
  parameter logic [11:0] RESET_DIV    = 12'h006,
  parameter int unsigned SETTLE_TICKS = 2,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic       rd_en_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  input  logic       tx_busy_i,
  input  logic       rx_busy_i,
  input  logic       br_i,
  output logic [7:0] dll_o,
  output logic [3:0] dlh_o,
  output logic       div_load_o,
  output logic       cfg_busy_o,
  output logic       cfg_done_o
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_IDLE, S_WAIT_TICK, S_APPLY, S_SETTLE} state_e;

  localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_TICKS - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic        force_q, force_d;
  logic [7:0]  stage_l_q, dll_q, rdata_q;
  logic [3:0]  stage_h_q, dlh_q;
  logic        tmo_q, ovr_q, zero_q, div_load_q;

  logic        busy, wr_drop, wr_ok, commit_req, zero_div, stat_rd;
  logic        set_tmo, apply, done;
  logic [7:0]  status, rd_mux;

  assign busy       = (state_q != S_IDLE);
  assign wr_ok      = wr_en_i && !busy;
  assign wr_drop    = wr_en_i && busy && (addr_i != 2'd3);
  assign commit_req = wr_ok && (addr_i == 2'd2) && wdata_i[0];
  assign zero_div   = ({stage_h_q, stage_l_q} == 12'h000);
  assign stat_rd    = rd_en_i && (addr_i == 2'd2);
  assign status     = {4'b0000, tmo_q, ovr_q, zero_q, busy};

  always_comb begin
    rd_mux = 8'h00;
    case (addr_i)
      2'd2: rd_mux = status;
`ifdef DIV_READBACK_EN
      2'd0: rd_mux = dll_q;
      2'd1: rd_mux = {4'b0000, dlh_q};
`endif
      default: rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    settle_cnt_d = settle_cnt_q;
    force_d      = force_q;
    set_tmo      = 1'b0;
    apply        = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        force_d = 1'b0;
        if (commit_req && !zero_div) begin
          state_d    = S_WAIT_IDLE;
          wait_cnt_d = 16'd0;
          force_d    = wdata_i[1];
        end
      end
      S_WAIT_IDLE: begin
        // a release on the final wait cycle takes priority over the abort
        if (force_q || (!tx_busy_i && !rx_busy_i)) begin
          state_d = S_WAIT_TICK;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          set_tmo = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_WAIT_TICK: if (br_i) state_d = S_APPLY;
      S_APPLY: begin
        apply        = 1'b1;
        settle_cnt_d = 4'd0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (br_i) begin
          if (settle_cnt_q >= SETTLE_LAST) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            settle_cnt_d = settle_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 16'd0;
      settle_cnt_q <= 4'd0;
      force_q      <= 1'b0;
      stage_l_q    <= RESET_DIV[7:0];
      stage_h_q    <= RESET_DIV[11:8];
      dll_q        <= RESET_DIV[7:0];
      dlh_q        <= RESET_DIV[11:8];
      rdata_q      <= 8'h00;
      tmo_q        <= 1'b0;
      ovr_q        <= 1'b0;
      zero_q       <= 1'b0;
      div_load_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      force_q      <= force_d;
      if (wr_ok && addr_i == 2'd0) stage_l_q <= wdata_i;
      if (wr_ok && addr_i == 2'd1) stage_h_q <= wdata_i[3:0];
      if (apply) begin
        dll_q <= stage_l_q;
        dlh_q <= stage_h_q;
      end
      div_load_q <= apply;
      // read-clear loses to a set arriving in the same cycle
      tmo_q  <= set_tmo | (tmo_q & ~stat_rd);
      ovr_q  <= wr_drop | (ovr_q & ~stat_rd);
      zero_q <= (commit_req & zero_div) | (zero_q & ~stat_rd);
      if (rd_en_i) rdata_q <= rd_mux;
    end
  end

  assign rdata_o    = rdata_q;
  assign dll_o      = dll_q;
  assign dlh_o      = dlh_q;
  assign div_load_o = div_load_q;
  assign cfg_busy_o = busy;
  assign cfg_done_o = done & ~rst_i;

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Bench for baud_cfg_ctrl: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_baud_cfg_ctrl;
  localparam int TMO = 32;
  localparam int ST  = 2;

  logic       clk = 1'b0, rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, tx_busy = 1'b0, rx_busy = 1'b0, br = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata, dll;
  logic [3:0] dlh;
  logic       div_load, cfg_busy, cfg_done;

  int n_cmp = 0, n_err = 0, cyc = 0, done_cnt = 0, last_br = 0, br_mode = 0;
  bit lat_chk = 0;

  baud_cfg_ctrl #(.RESET_DIV(12'h006), .SETTLE_TICKS(ST), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .rd_en_i(rd_en), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .tx_busy_i(tx_busy), .rx_busy_i(rx_busy),
    .br_i(br), .dll_o(dll), .dlh_o(dlh), .div_load_o(div_load),
    .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done));

  always #5 clk = ~clk;

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [11:0] m_div, m_stage;
  logic [7:0]  m_rdata;
  bit m_tmo, m_ovr, m_zro, m_load, m_rdv, m_ok;
  bit w_idle, w_tick, w_apply, w_settle, m_force;
  int waited, ticks;

  initial begin
    m_ok = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_div = 12'h006; m_stage = 12'h006; m_rdata = 8'h00;
        {m_tmo, m_ovr, m_zro, m_load, m_rdv} = '0;
        {w_idle, w_tick, w_apply, w_settle, m_force} = '0;
        waited = 0; ticks = 0; m_ok = 1;
      end else begin
        bit busy;
        busy  = w_idle | w_tick | w_apply | w_settle;
        m_rdv = rd_en;
        if (rd_en) begin
          case (addr)
            2'd2: m_rdata = {4'b0, m_tmo, m_ovr, m_zro, busy};
`ifdef DIV_READBACK_EN
            2'd0: m_rdata = m_div[7:0];
            2'd1: m_rdata = {4'b0, m_div[11:8]};
`endif
            default: m_rdata = 8'h00;
          endcase
          if (addr == 2'd2) {m_tmo, m_ovr, m_zro} = '0;
        end
        m_load = 0;
        if (w_apply) begin
          m_div = m_stage; m_load = 1; w_apply = 0; w_settle = 1; ticks = 0;
        end else if (w_settle) begin
          if (br) begin ticks++; if (ticks == ST) w_settle = 0; end
        end else if (w_tick) begin
          if (br) begin w_tick = 0; w_apply = 1; end
        end else if (w_idle) begin
          if (m_force || (!tx_busy && !rx_busy)) begin
            w_idle = 0; w_tick = 1;
          end else begin
            waited++;
            if (waited == TMO) begin m_tmo = 1; w_idle = 0; end
          end
        end
        if (wr_en && addr != 2'd3) begin
          if (busy) m_ovr = 1;
          else if (addr == 2'd0) m_stage[7:0] = wdata;
          else if (addr == 2'd1) m_stage[11:8] = wdata[3:0];
          else if (wdata[0]) begin
            if (m_stage == 12'h000) m_zro = 1;
            else begin w_idle = 1; waited = 0; m_force = wdata[1]; end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (br) last_br = cyc;
      if (cfg_done === 1'b1) done_cnt++;
      if (m_ok) begin
        check("dll", dll, m_div[7:0]);
        check("dlh", dlh, m_div[11:8]);
        check("div_load", div_load, m_load);
        check("cfg_busy", cfg_busy, w_idle | w_tick | w_apply | w_settle);
        check("cfg_done", cfg_done, w_settle && br && ticks == ST - 1 && !rst);
        if (m_rdv) check("rdata", rdata, m_rdata);
        if (lat_chk && div_load) begin
          check("apply_latency", 16'(cyc - last_br), 16'd2);
          lat_chk = 0;
        end
      end
    end
  end

  // ---------------- br source ----------------
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (br_mode == 1) begin
        if (cnt >= 6) begin br = 1; cnt = 0; end else begin br = 0; cnt++; end
      end else if (br_mode == 2) br = ($urandom_range(0, 4) == 0);
      else br = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    wr_en = 1; addr = a; wdata = d; tick(); wr_en = 0;
  endtask

  task automatic rd(logic [1:0] a, output logic [7:0] v);
    rd_en = 1; addr = a; tick(); rd_en = 0; v = rdata;
  endtask

  task automatic wait_load(string nm);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (div_load === 1'b1) ok = 1; else tick();
    end
    check(nm, 16'(ok), 16'd1);
  endtask

  task automatic wait_free(string nm);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (cfg_busy === 1'b0) ok = 1; else tick();
    end
    check(nm, 16'(ok), 16'd1);
  endtask

  localparam bit RB = `ifdef DIV_READBACK_EN 1'b1 `else 1'b0 `endif;

  initial begin
    logic [7:0] v;
    int d0;
    // 1: reset state
    rst = 1; tick(2); rst = 0;
    check("rst_dll", dll, 8'h06);
    check("rst_dlh", dlh, 4'h0);
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    rd(2'd2, v); check("rst_status", v, 8'h00);
    rd(2'd0, v); check("rb_dll_rst", v, RB ? 8'h06 : 8'h00);

    // 2: normal commit, br every 7 clocks
    wr(2'd0, 8'h0A); wr(2'd1, 8'hF1); br_mode = 1; lat_chk = 1;
    d0 = done_cnt;
    wr(2'd2, 8'h01);
    wait_load("t2_load");
    check("t2_dll", dll, 8'h0A);
    check("t2_dlh", dlh, 4'h1);
    tick(); check("t2_load_width", div_load, 1'b0);
    wait_free("t2_free");
    check("t2_done_once", 16'(done_cnt - d0), 16'd1);
    rd(2'd1, v); check("rb_dlh", v, RB ? 8'h01 : 8'h00);

    // 3: timeout with tx busy, then forced commit
    tx_busy = 1;
    wr(2'd0, 8'h33); wr(2'd1, 8'h00);
    d0 = done_cnt;
    wr(2'd2, 8'h01); tick(40);
    rd(2'd2, v); check("t3_status", v, 8'h08);
    check("t3_dll_kept", dll, 8'h0A);
    check("t3_no_done", 16'(done_cnt - d0), 16'd0);
    wr(2'd2, 8'h03);
    wait_load("t3_force_load");
    check("t3_force_dll", dll, 8'h33);
    wait_free("t3_free"); tx_busy = 0;

    // 4: zero divisor rejected
    wr(2'd0, 8'h00); wr(2'd1, 8'h00); wr(2'd2, 8'h01);
    check("t4_busy", cfg_busy, 1'b0);
    rd(2'd2, v); check("t4_status", v, 8'h02);
    rd(2'd2, v); check("t4_status2", v, 8'h00);

    // 5: overrun during SETTLE, set-vs-clear collision
    wr(2'd0, 8'h21); wr(2'd2, 8'h01);
    wait_load("t5_load");
    wr(2'd0, 8'h55);
    rd(2'd2, v); check("t5_ovr_set", 16'(v[2]), 16'd1);
    rd_en = 1; wr_en = 1; addr = 2'd2; wdata = 8'h00; tick(); rd_en = 0; wr_en = 0;
    check("t5_pre_val", 16'(rdata[2]), 16'd0);
    rd(2'd2, v); check("t5_ovr_kept", 16'(v[2]), 16'd1);
    wait_free("t5_free");
    wr(2'd2, 8'h01);
    wait_load("t5_reload");
    check("t5_stage_kept", dll, 8'h21);
    wait_free("t5_free2");

    // 6: reset during SETTLE
    wr(2'd0, 8'h44); wr(2'd2, 8'h01);
    wait_load("t6_load");
    d0 = done_cnt;
    tick(); rst = 1; tick(); rst = 0;
    check("t6_dll", dll, 8'h06);
    check("t6_busy", cfg_busy, 1'b0);
    check("t6_no_done", 16'(done_cnt - d0), 16'd0);

    // random traffic
    br_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 999) == 0);
      rd_en = ($urandom_range(0, 3) == 0);
      wr_en = ($urandom_range(0, 4) == 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 7) == 0) tx_busy = ~tx_busy;
      if ($urandom_range(0, 9) == 0) rx_busy = ~rx_busy;
      tick();
    end
    {rst, rd_en, wr_en, tx_busy, rx_busy} = '0;
    br_mode = 0;
    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
